// File: rtl/aes_invsub_seq.sv
// Byte-serial InvSubBytes sequencer: buffers a block, feeds one shared inverse S-box, streams results out.
// Latency: first out_valid NBYTES+SBOX_LAT+1 cycles after the last input accept; one byte/cycle after that.
// Backpressure: in_ready only in IDLE/LOAD; out_byte held while out_ready=0; ena=0 freezes everything.
module aes_invsub_seq #(
    parameter int NBYTES   = 16,
    parameter int SBOX_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       clr,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       sbox_en,
    output logic [7:0] sbox_in,
    input  logic [7:0] sbox_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       busy,
    output logic       done
);

    localparam int PW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW = $clog2(NBYTES + SBOX_LAT + 1);
    localparam int SL = (SBOX_LAT > 0) ? SBOX_LAT : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(NBYTES - 1);
    localparam logic [CW-1:0] ISS_END  = CW'(NBYTES);
    localparam logic [CW-1:0] SUB_LAST = CW'(NBYTES + SBOX_LAT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SUB, DRAIN} state_t;

    state_t        state;
    logic [PW-1:0] ld_ptr;
    logic [PW-1:0] iss_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] sub_cnt;
    logic [7:0]    mem [NBYTES];
    logic          done_r;
    logic          wb_vld;
    logic [PW-1:0] wb_idx;
    logic          in_load;

    assign in_load   = (state == IDLE) || (state == LOAD);
    assign in_ready  = ena & ~clr & in_load;
    assign sbox_en   = ena & (state == SUB) & (sub_cnt < ISS_END);
    assign sbox_in   = sbox_en ? mem[iss_ptr] : 8'h00;
    assign out_valid = ena & ~clr & (state == DRAIN);
    assign out_byte  = mem[rd_ptr];
    assign busy      = (state == SUB) || (state == DRAIN);
    assign done      = done_r & ena;

    // Writeback tracker mirrors the S-box pipeline; it must stall with ena exactly as the S-box does.
    generate
        if (SBOX_LAT == 0) begin : g_wb_comb
            assign wb_vld = sbox_en;
            assign wb_idx = iss_ptr;
        end else begin : g_wb_pipe
            logic [SL-1:0] vld_sr;
            logic [PW-1:0] idx_sr [SL];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_sr <= '0;
                    for (int i = 0; i < SL; i++) idx_sr[i] <= '0;
                end else if (clr) begin
                    vld_sr <= '0;
                    for (int i = 0; i < SL; i++) idx_sr[i] <= '0;
                end else if (ena) begin
                    vld_sr[0] <= sbox_en;
                    idx_sr[0] <= iss_ptr;
                    for (int i = 1; i < SL; i++) begin
                        vld_sr[i] <= vld_sr[i-1];
                        idx_sr[i] <= idx_sr[i-1];
                    end
                end
            end

            assign wb_vld = vld_sr[SL-1];
            assign wb_idx = idx_sr[SL-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ld_ptr  <= '0;
            iss_ptr <= '0;
            rd_ptr  <= '0;
            sub_cnt <= '0;
            done_r  <= 1'b0;
            for (int i = 0; i < NBYTES; i++) mem[i] <= 8'h00;
        end else begin
            done_r <= 1'b0;
            if (clr) begin
                state   <= IDLE;
                ld_ptr  <= '0;
                iss_ptr <= '0;
                rd_ptr  <= '0;
                sub_cnt <= '0;
            end else if (ena) begin
                case (state)
                    IDLE, LOAD: begin
                        if (in_valid) begin
                            mem[ld_ptr] <= in_byte;
                            if (ld_ptr == LAST_PTR) begin
                                ld_ptr <= '0;
                                state  <= SUB;
                            end else begin
                                ld_ptr <= ld_ptr + 1'b1;
                                state  <= LOAD;
                            end
                        end
                    end
                    SUB: begin
                        if (sbox_en)
                            iss_ptr <= (iss_ptr == LAST_PTR) ? '0 : iss_ptr + 1'b1;
                        if (wb_vld)
                            mem[wb_idx] <= sbox_out;
                        // The final cycle of SUB is the one carrying the last writeback.
                        if (sub_cnt == SUB_LAST) begin
                            sub_cnt <= '0;
                            state   <= DRAIN;
                        end else begin
                            sub_cnt <= sub_cnt + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (out_ready) begin
                            if (rd_ptr == LAST_PTR) begin
                                rd_ptr <= '0;
                                state  <= IDLE;
                                done_r <= 1'b1;
                            end else begin
                                rd_ptr <= rd_ptr + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
